// File: rtl/multiword_adder_seq.sv
// Multi-cycle W-bit adder/subtractor: one N-bit ripple adder reused over K chunks,
// LSB chunk first, with the inter-chunk carry held in a register.

module n_bit_rc_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);
   logic c;

   always_comb begin
      s = '0;
      c = cin;
      for (int i = 0; i < N; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

// state | meaning
// IDLE  | ready for a new operation
// RUN   | one chunk added per cycle, idx selects the chunk
// DONE  | result presented, waiting for out_ready
module multiword_adder_seq #(
   parameter int N = 8,
   parameter int K = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*K-1:0]   a,
   input  logic [N*K-1:0]   b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N*K-1:0]   sum,
   output logic             cout,
   output logic             overflow
);
   localparam int W  = N * K;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [IW-1:0] LAST = IW'(K - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   a_r, b_r;
   logic           carry;
   logic [IW-1:0]  idx;
   logic [N-1:0]   add_s;
   logic           add_co;
   logic           last;

   n_bit_rc_adder #(.N(N)) u_add (
      .a    (a_r[idx*N +: N]),
      .b    (b_r[idx*N +: N]),
      .cin  (carry),
      .s    (add_s),
      .cout (add_co)
   );

   assign last = (idx == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1, so the operand is inverted once at accept time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r      <= '0;
         b_r      <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  b_r   <= sub ? ~b : b;
                  carry <= sub | cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               sum[idx*N +: N] <= add_s;
               carry           <= add_co;
               if (last) begin
                  cout     <= add_co;
                  overflow <= (a_r[W-1] == b_r[W-1]) && (add_s[N-1] != a_r[W-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Bench for multiword_adder_seq: directed cases on K=4 plus random ops on K=1,3,4
// against an integer-arithmetic reference model.

module tb_multiword_adder_seq;
   logic        clk = 1'b0;
   logic        reset, in_valid, cin, sub, out_ready;
   logic [31:0] a, b;
   logic        rdy4, rdy3, rdy1, v4, v3, v1, co4, co3, co1, ov4, ov3, ov1;
   logic [31:0] s4;
   logic [23:0] s3;
   logic [7:0]  s1;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   multiword_adder_seq #(.N(8), .K(4)) u_k4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(v4), .out_ready(out_ready),
      .sum(s4), .cout(co4), .overflow(ov4));

   multiword_adder_seq #(.N(8), .K(3)) u_k3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3),
      .a(a[23:0]), .b(b[23:0]), .cin(cin), .sub(sub), .out_valid(v3), .out_ready(out_ready),
      .sum(s3), .cout(co3), .overflow(ov3));

   multiword_adder_seq #(.N(8), .K(1)) u_k1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(v1), .out_ready(out_ready),
      .sum(s1), .cout(co1), .overflow(ov1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: true integer result, truncated to w bits; overflow is the
   // mathematical signed result falling outside the w-bit range.
   function automatic void model(input longint av_in, input longint bv_in, input bit ci,
                                 input bit sb, input int w, output longint s,
                                 output bit co, output bit ov);
      longint m, av, bv, sa, sbv, t, full, half;
      m    = (longint'(1) <<< w) - 1;
      half = longint'(1) <<< (w - 1);
      av   = av_in & m;
      bv   = bv_in & m;
      sa   = (av >= half) ? av - (m + 1) : av;
      sbv  = (bv >= half) ? bv - (m + 1) : bv;
      if (sb) begin
         s  = (av - bv) & m;
         co = (av >= bv);
         t  = sa - sbv;
      end else begin
         full = av + bv + longint'(ci);
         s    = full & m;
         co   = ((full >>> w) & 1) != 0;
         t    = sa + sbv + longint'(ci);
      end
      ov = (t > half - 1) || (t < -half);
   endfunction

   task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                         input logic sb);
      a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic run4(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb, input logic [31:0] es,
                       input logic eco, input logic eov);
      int lat;
      lat = 0;
      launch(av, bv, ci, sb);
      while (!v4 && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd4);
      chk({tag, "_sum"}, 64'(s4), 64'(es));
      chk({tag, "_cout"}, 64'(co4), 64'(eco));
      chk({tag, "_ovf"}, 64'(ov4), 64'(eov));
      step();
      chk({tag, "_idle"}, 64'({rdy4, v4}), 64'b10);
   endtask

   initial begin
      bit     seen4, seen3, seen1, co, ov, aborted_valid;
      longint e4, e3, e1;
      bit     c4, c3, c1, o4, o3, o1;
      logic [31:0] ra, rb;
      logic        rc, rs;

      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      chk("rst_state", 64'({rdy4, v4, co4, ov4}), 64'b1000);
      chk("rst_sum", 64'(s4), 64'd0);
      reset = 1'b0;
      step();

      run4("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      run4("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run4("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run4("t3b", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

      // Backpressure: result must hold and a second request must be ignored.
      out_ready = 1'b0;
      launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      repeat (4) step();
      chk("bp_valid", 64'(v4), 64'd1);
      a = 32'hAAAA_AAAA; b = 32'h5555_5555; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold", 64'({v4, rdy4}), 64'b10);
         chk("bp_sum", 64'(s4), 64'h2345_6789);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_release", 64'({v4, rdy4}), 64'b01);
      step();
      chk("bp_single", 64'({v4, rdy4}), 64'b01);

      // Reset in the second RUN cycle aborts the operation.
      launch(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
      step();
      reset = 1'b1;
      #1;
      chk("abort_rst", 64'({v4, rdy4, co4, ov4}), 64'b0100);
      chk("abort_sum", 64'(s4), 64'd0);
      step();
      reset = 1'b0;
      aborted_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (v4) aborted_valid = 1'b1;
      end
      chk("abort_novalid", 64'(aborted_valid), 64'd0);
      chk("abort_ready", 64'(rdy4), 64'd1);
      run4("t5", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ~ra;
            1: ra = 32'hFFFF_FFFF;
            default: ;
         endcase
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         model(longint'(ra), longint'(rb), rc, rs, 32, e4, c4, o4);
         model(longint'(ra), longint'(rb), rc, rs, 24, e3, c3, o3);
         model(longint'(ra), longint'(rb), rc, rs, 8,  e1, c1, o1);
         chk("rnd_ready", 64'({rdy4, rdy3, rdy1}), 64'b111);
         launch(ra, rb, rc, rs);
         seen4 = 1'b0; seen3 = 1'b0; seen1 = 1'b0;
         for (int cyc = 0; cyc <= 6; cyc++) begin
            if (cyc > 0) step();
            if (v1 && !seen1) begin
               seen1 = 1'b1;
               chk("k1_lat", 64'(cyc), 64'd1);
               chk("k1_res", {54'd0, co1, ov1, s1}, {54'd0, c1, o1, e1[7:0]});
            end
            if (v3 && !seen3) begin
               seen3 = 1'b1;
               chk("k3_lat", 64'(cyc), 64'd3);
               chk("k3_res", {38'd0, co3, ov3, s3}, {38'd0, c3, o3, e3[23:0]});
            end
            if (v4 && !seen4) begin
               seen4 = 1'b1;
               chk("k4_lat", 64'(cyc), 64'd4);
               chk("k4_res", {30'd0, co4, ov4, s4}, {30'd0, c4, o4, e4[31:0]});
            end
         end
         chk("rnd_seen", 64'({seen4, seen3, seen1}), 64'b111);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
